// File: rtl/spi_buffer_master_if.sv
// Buffer-memory port bundle between spi_buffer_master (master) and the
// register-file buffer (slave): one combinational read port, one write port.
interface spi_buffer_master_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] mem_raddr_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_waddr_o;
   logic [DATA_W-1:0] mem_wdata_o;

   modport master (
      output mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport slave (
      input  mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/spi_buffer_master.sv
// SPI mode-0 master that streams buffer words out MSB-first and writes the
// received words back in place. Optional macro SPI_LOOPBACK_EN samples mosi_o.
module spi_buffer_master #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 5,
   parameter int HALF_PER = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [ADDR_W-1:0]    n_tx_i,
   input  logic                 all_ones_i,
   input  logic                 all_zeros_i,
   spi_buffer_master_if.master  mem,
   output logic                 sclk_o,
   output logic                 cs_n_o,
   output logic                 mosi_o,
   input  logic                 miso_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [ADDR_W-1:0]    cnt_o
);
   localparam int DIV_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PER - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   n_q, n_d;
   logic                ones_q, ones_d;
   logic                zeros_q, zeros_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                rx_bit;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = miso_i;
   assign rx_bit      = mosi_q;
`else
   assign rx_bit      = miso_i;
`endif

   always_comb begin
      // NOTE: every _d starts as its _q so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      n_d     = n_q;
      ones_d  = ones_q;
      zeros_d = zeros_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      tx_d    = tx_q;
      rx_d    = rx_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               n_d     = n_tx_i;
               ones_d  = all_ones_i;
               zeros_d = all_zeros_i;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = (n_tx_i == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (ones_q)       tx_d = '1;
            else if (zeros_q) tx_d = '0;
            else              tx_d = mem.mem_rdata_i;
            mosi_d  = tx_d[DATA_W-1];
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  rx_d = {rx_q[DATA_W-2:0], rx_bit};
               end else begin
                  // Falling edge: present the next bit; the last fall closes the word.
                  tx_d   = tx_q << 1;
                  mosi_d = tx_q[DATA_W-2];
                  bit_d  = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) state_d = STORE;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         STORE: begin
            cnt_d   = cnt_q + 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = (cnt_d == n_q) ? DONE : LOAD;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         n_q     <= '0;
         ones_q  <= 1'b0;
         zeros_q <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
      end else begin
         // NOTE: non-blocking so every register updates from pre-edge values.
         state_q <= state_d;
         n_q     <= n_d;
         ones_q  <= ones_d;
         zeros_q <= zeros_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
      end
   end

   assign mem.mem_raddr_o = idx_q;
   assign mem.mem_we_o    = (state_q == STORE);
   assign mem.mem_waddr_o = idx_q;
   assign mem.mem_wdata_o = rx_q;
   assign sclk_o          = sclk_q;
   assign mosi_o          = mosi_q;
   assign cs_n_o          = !(state_q inside {LOAD, SHIFT, STORE});
   assign busy_o          = (state_q != IDLE);
   assign done_o          = (state_q == DONE);
   assign cnt_o           = cnt_q;
endmodule

// File: tb/tb_spi_buffer_master.sv
// Randomized scoreboard bench for spi_buffer_master: a word-level reference
// model predicts sent frames, write-backs, timing and done counts.
module tb_spi_buffer_master;
   localparam int DW       = 8;
   localparam int AW       = 5;
   localparam int HP       = 2;
   localparam int DEPTH    = 1 << AW;
   localparam int WORD_CYC = 2 * HP * DW + 2;
`ifdef SPI_LOOPBACK_EN
   localparam bit LOOPBACK = 1'b1;
`else
   localparam bit LOOPBACK = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [AW-1:0] n_tx_i;
   logic          all_ones_i;
   logic          all_zeros_i;
   logic          sclk_o, cs_n_o, mosi_o, miso_i, busy_o, done_o;
   logic [AW-1:0] cnt_o;

   spi_buffer_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   spi_buffer_master #(.DATA_W(DW), .ADDR_W(AW), .HALF_PER(HP)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start_i),
      .n_tx_i      (n_tx_i),
      .all_ones_i  (all_ones_i),
      .all_zeros_i (all_zeros_i),
      .mem         (bus),
      .sclk_o      (sclk_o),
      .cs_n_o      (cs_n_o),
      .mosi_o      (mosi_o),
      .miso_i      (miso_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .cnt_o       (cnt_o)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int start_cyc   = 0;
   int cs_rise_cnt = 0;
   int done_seen   = 0;

   // Buffer memory seen by the DUT, plus the reference model's view of it.
   logic [DW-1:0] buf_mem [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;

   assign bus.mem_rdata_i = buf_mem[bus.mem_raddr_o];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_en)          buf_mem[pl_addr] <= pl_data;
      if (bus.mem_we_o)   buf_mem[bus.mem_waddr_o] <= bus.mem_wdata_o;
   end

   wr_t           exp_wr_q[$];
   logic [DW-1:0] exp_tx_q[$];
   int            exp_done_q[$];
   logic [DW-1:0] slave_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor + SPI slave, all evaluated on the falling clk edge.
   logic          sclk_prev = 1'b0;
   logic          cs_prev   = 1'b1;
   logic [DW-1:0] slave_sh  = '0;
   int            s_bits    = 0;
   logic [DW-1:0] tx_cap    = '0;
   int            tx_bits   = 0;

   assign miso_i = slave_sh[DW-1];

   always @(negedge clk) begin
      if (bus.mem_we_o) begin
         if (exp_wr_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            check("wr_addr", bus.mem_waddr_o, e.addr);
            check("wr_data", bus.mem_wdata_o, e.data);
            check("wr_latency", cyc - start_cyc, e.cyc);
         end
      end
      if (done_o) begin
         done_seen++;
         if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
         else                        check("done_cnt", cnt_o, exp_done_q.pop_front());
      end
      if (sclk_o && !sclk_prev) begin
         tx_cap = {tx_cap[DW-2:0], mosi_o};
         tx_bits++;
         if (tx_bits == DW) begin
            tx_bits = 0;
            if (exp_tx_q.size() == 0) check("unexpected_frame", 1, 0);
            else                      check("mosi_word", tx_cap, exp_tx_q.pop_front());
         end
      end
      if (cs_prev && !cs_n_o) begin
         slave_sh = (slave_q.size() != 0) ? slave_q.pop_front() : DW'($urandom);
         s_bits   = 0;
      end else if (!sclk_o && sclk_prev && !cs_n_o) begin
         s_bits++;
         if (s_bits == DW) begin
            slave_sh = (slave_q.size() != 0) ? slave_q.pop_front() : DW'($urandom);
            s_bits   = 0;
         end else begin
            slave_sh = slave_sh << 1;
         end
      end
      if (cs_n_o && !cs_prev) begin
         cs_rise_cnt++;
         tx_bits = 0;
      end
      sclk_prev = sclk_o;
      cs_prev   = cs_n_o;
   end

   task automatic set_mem(input int addr, input logic [DW-1:0] val);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = AW'(addr);
      pl_data = val;
      ref_mem[addr] = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_sclk"},  sclk_o, 0);
      check({tag, "_cs_n"},  cs_n_o, 1);
      check({tag, "_mosi"},  mosi_o, 0);
      check({tag, "_we"},    bus.mem_we_o, 0);
      check({tag, "_raddr"}, bus.mem_raddr_o, 0);
      check({tag, "_waddr"}, bus.mem_waddr_o, 0);
      check({tag, "_wdata"}, bus.mem_wdata_o, 0);
      check({tag, "_busy"},  busy_o, 0);
      check({tag, "_done"},  done_o, 0);
      check({tag, "_cnt"},   cnt_o, 0);
   endtask

   // Reference model: word k sends ref_mem[k] (or an override) and gets the slave word back.
   task automatic run_burst(input int n, input bit ones, input bit zeros,
                            input bit interfere, input bit late_start, input int force_sw);
      logic [DW-1:0] sent, sw, wd;
      int  cs0, d0, budget;
      bit  seen;
      slave_q.delete();
      for (int k = 0; k < n; k++) begin
         int a;
         a    = k % DEPTH;
         sent = ones ? {DW{1'b1}} : (zeros ? {DW{1'b0}} : ref_mem[a]);
         sw   = (force_sw >= 0) ? DW'(force_sw) : DW'($urandom);
         wd   = LOOPBACK ? sent : sw;
         slave_q.push_back(sw);
         exp_tx_q.push_back(sent);
         exp_wr_q.push_back('{addr: AW'(a), data: wd, cyc: WORD_CYC * (k + 1)});
         ref_mem[a] = wd;
      end
      exp_done_q.push_back(n);
      cs0 = cs_rise_cnt;
      d0  = done_seen;
      @(negedge clk);
      start_i     = 1'b1;
      n_tx_i      = AW'(n);
      all_ones_i  = ones;
      all_zeros_i = zeros;
      start_cyc   = cyc;
      @(negedge clk);
      start_i     = 1'b0;
      n_tx_i      = AW'($urandom);
      all_ones_i  = 1'($urandom);
      all_zeros_i = 1'($urandom);
      budget = n * WORD_CYC + 20;
      seen   = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_o) begin
            seen = 1'b1;
            if (late_start) begin
               start_i = 1'b1;
               n_tx_i  = AW'(3);
               @(negedge clk);
               start_i = 1'b0;
            end
            break;
         end
         if (interfere && i == 5) begin
            start_i = 1'b1;
            n_tx_i  = AW'(7);
         end else if (interfere && i == 6) begin
            start_i = 1'b0;
         end
         @(negedge clk);
      end
      check("burst_done_seen", seen, 1);
      repeat (3) @(negedge clk);
      check("busy_after", busy_o, 0);
      check("cs_rises", cs_rise_cnt - cs0, (n > 0) ? 1 : 0);
      check("done_pulses", done_seen - d0, 1);
      check("left_writes", exp_wr_q.size(), 0);
      check("left_frames", exp_tx_q.size(), 0);
      exp_wr_q.delete();
      exp_tx_q.delete();
      exp_done_q.delete();
   endtask

   task automatic abort_test();
      int d0;
      slave_q.delete();
      slave_q.push_back(DW'($urandom));
      slave_q.push_back(DW'($urandom));
      d0 = done_seen;
      @(negedge clk);
      start_i   = 1'b1;
      n_tx_i    = AW'(2);
      start_cyc = cyc;
      @(negedge clk);
      start_i = 1'b0;
      // Bit 4 of word 0 occupies cycles 18..21 after the start cycle.
      repeat (18) @(negedge clk);
      check("abort_cs_low_before", cs_n_o, 0);
      #2 rst = 1'b1;
      #1 check_reset("abort");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_cs_idle", cs_n_o, 1);
      check("abort_no_done", done_seen - d0, 0);
      slave_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      start_i     = 1'b0;
      n_tx_i      = '0;
      all_ones_i  = 1'b0;
      all_zeros_i = 1'b0;
      #3 check_reset("init");
      for (int i = 0; i < DEPTH; i++) set_mem(i, DW'($urandom));
      rst = 1'b0;

      set_mem(0, 8'hA5);
      run_burst(1, 1'b0, 1'b0, 1'b0, 1'b0, 'h3C);

      set_mem(0, 8'h11);
      set_mem(1, 8'h22);
      set_mem(2, 8'h33);
      run_burst(3, 1'b0, 1'b0, 1'b0, 1'b0, -1);

      set_mem(0, 8'h00);
      run_burst(1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
      run_burst(1, 1'b0, 1'b1, 1'b0, 1'b0, -1);

      run_burst(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

      run_burst(2, 1'b0, 1'b0, 1'b1, 1'b1, -1);

      abort_test();

      for (int t = 0; t < 8; t++) begin
         run_burst($urandom_range(1, 6), ($urandom % 5) == 0, ($urandom % 5) == 0,
                   1'($urandom), 1'($urandom), -1);
      end

      run_burst(DEPTH - 1, 1'b0, 1'b0, 1'b1, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
